// File: rtl/alu_issue_if.sv
// Instruction issue handshake between the decoder and alu_issue.
// The decoder holds the master side; alu_issue holds the slave side.
interface alu_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback controller for the registered 16-bit ALU: 8x16 register file, operand issue, result writeback.
// Build option ALU_FWD_EN: forward the ALU result into dependent operands instead of stalling one cycle.
module alu_issue (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       issue,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_res,
  input  logic [3:0]       alu_flags,
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [15:0]      wb_data,
  output logic [3:0]       flags_q,
  input  logic [2:0]       dbg_addr,
  output logic [15:0]      dbg_data
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_NOT = 4'd15
  } op_e;

  // Operands/opcode held while the ALU samples them.
  typedef struct packed {
    logic        live;
    logic [3:0]  op;
    logic [2:0]  rd;
`ifdef ALU_FWD_EN
    logic [2:0]  rs1;
    logic [2:0]  rs2;
`endif
    logic [15:0] a;
    logic [15:0] b;
  } s1_t;

  function automatic logic is_live(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT: is_live = 1'b1;
      default:                                                       is_live = 1'b0;
    endcase
  endfunction

  logic [15:0] regs [1:7];
  s1_t         s1_q;
  s1_t         s1_d;
  logic        s2_live;
  logic [2:0]  s2_rd;

  logic        accept;
  logic        wb_we;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        fwd_a;
  logic        fwd_b;

  // The instruction in S2 writes back on this edge; r0 writes are dropped.
  assign wb_we  = s2_live && (s2_rd != 3'd0);
  assign accept = issue.in_valid && issue.in_ready;

`ifdef ALU_FWD_EN
  assign issue.in_ready = 1'b1;
  assign fwd_a = s1_q.live && s2_live && (s2_rd != 3'd0) && (s1_q.rs1 == s2_rd);
  assign fwd_b = s1_q.live && s2_live && (s2_rd != 3'd0) && (s1_q.rs2 == s2_rd);
`else
  logic raw_hazard;
  // S1's result only reaches the register file two edges later, so a reader must wait one bubble.
  assign raw_hazard = s1_q.live && (s1_q.rd != 3'd0) &&
                      ((issue.in_rs1 == s1_q.rd) || (issue.in_rs2 == s1_q.rd));
  assign issue.in_ready = !(issue.in_valid && raw_hazard);
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Register read with write-through from the writeback on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src_a = '0;
    src_b = '0;
    if (issue.in_rs1 != 3'd0) src_a = regs[issue.in_rs1];
    if (issue.in_rs2 != 3'd0) src_b = regs[issue.in_rs2];
    if (wb_we && (s2_rd == issue.in_rs1)) src_a = alu_res;
    if (wb_we && (s2_rd == issue.in_rs2)) src_b = alu_res;
  end

  // NOPs enter S1 as an empty slot, which already drives alu_op=0 and zero operands.
  always_comb begin
    s1_d = '0;
    if (accept && is_live(issue.in_op)) begin
      s1_d.live = 1'b1;
      s1_d.op   = issue.in_op;
      s1_d.rd   = issue.in_rd;
`ifdef ALU_FWD_EN
      s1_d.rs1  = issue.in_rs1;
      s1_d.rs2  = issue.in_rs2;
`endif
      s1_d.a    = src_a;
      s1_d.b    = src_b;
    end
  end

  assign alu_op = s1_q.op;
  assign alu_a  = fwd_a ? alu_res : s1_q.a;
  assign alu_b  = fwd_b ? alu_res : s1_q.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_live  <= 1'b0;
      s2_rd    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flags_q  <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is reset here like any flop.
      for (int i = 1; i < 8; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
      s1_q     <= s1_d;
      s2_live  <= s1_q.live;
      s2_rd    <= s1_q.rd;
      wb_valid <= s2_live;
      if (s2_live) begin
        wb_rd   <= s2_rd;
        wb_data <= alu_res;
        flags_q <= alu_flags;
      end
      if (wb_we) regs[s2_rd] <= alu_res;
    end
  end

  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

endmodule
